// File: rtl/fork_join_scheduler.sv
// fork_join_scheduler: forks one operand onto a set of worker lanes and joins
// their completions under a JOIN_ALL / JOIN_ANY / JOIN_NONE policy, with a
// watchdog that forces completion when lanes hang.
//
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   start           job request; accepted only while start_ready is high
//   start_ready     idle and no requested lane is still outstanding
//   mode            00 JOIN_ALL, 01 JOIN_ANY, 10 JOIN_NONE, 11 JOIN_ALL
//   lane_en         lanes the job is forked onto
//   data_in         job operand
//   lane_req        one-cycle dispatch pulse per job lane
//   lane_data       captured operand broadcast to the lanes
//   lane_ack        one-cycle completion pulse per lane
//   lane_res        per-lane results, valid with lane_ack
//   outstanding     lanes dispatched but not yet acked (across jobs)
//   done            one-cycle job completion pulse
//   result          job result, held until the next done
//   timeout         with done: the watchdog ended the job
//   err_spurious    sticky: ack seen on a lane that was not outstanding
module fork_join_scheduler #(
  parameter int unsigned N_LANES     = 3,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        start_ready,
  input  logic [1:0]                  mode,
  input  logic [N_LANES-1:0]          lane_en,
  input  logic [DATA_W-1:0]           data_in,
  output logic [N_LANES-1:0]          lane_req,
  output logic [DATA_W-1:0]           lane_data,
  input  logic [N_LANES-1:0]          lane_ack,
  input  logic [N_LANES*DATA_W-1:0]   lane_res,
  output logic [N_LANES-1:0]          outstanding,
  output logic                        done,
  output logic [DATA_W-1:0]           result,
  output logic                        timeout,
  output logic                        err_spurious
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_EXT = CNT_W + 1;
  localparam logic [CNT_W:0] TO_VAL = CNT_EXT'(TIMEOUT_CYC);
  localparam logic [1:0] MODE_ANY  = 2'b01;
  localparam logic [1:0] MODE_NONE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [N_LANES-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [N_LANES-1:0]   req_q, req_d;
  logic [N_LANES-1:0]   out_q, out_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic                 done_q, done_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic                 timeout_q, timeout_d;
  logic                 err_q, err_d;

  logic [N_LANES-1:0]   job_ack;
  logic [DATA_W-1:0]    ack_sum;
  logic [DATA_W-1:0]    any_res;
  logic                 any_hit;
  logic                 join_met;
  logic                 expire;

  // Readiness depends on the live lane_en, so it cannot be registered.
  assign start_ready = rst_n && (state_q == S_IDLE) && ((lane_en & out_q) == '0);

  // Watchdog fires on the WAIT cycle that brings the count to TIMEOUT_CYC.
  assign expire = (TIMEOUT_CYC != 0) && (({1'b0, cnt_q} + CNT_EXT'(1)) == TO_VAL);

  // Next-state, ack bookkeeping and join evaluation.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    data_d    = data_q;
    req_d     = '0;
    out_d     = out_q & ~lane_ack;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    result_d  = result_q;
    timeout_d = 1'b0;
    err_d     = err_q | (|(lane_ack & ~out_q));
    // Only acks from lanes of the current job contribute to its result.
    job_ack   = lane_ack & out_q & mask_q;
    ack_sum   = '0;
    any_hit   = 1'b0;
    any_res   = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (job_ack[i]) begin
        ack_sum = ack_sum + lane_res[i*DATA_W +: DATA_W];
        if (!any_hit) begin
          any_hit = 1'b1;
          any_res = lane_res[i*DATA_W +: DATA_W];
        end
      end
    end
    join_met = (mode_q == MODE_ANY) ? any_hit : ((out_d & mask_q) == '0);

    case (state_q)
      S_IDLE: begin
        if (start && start_ready) begin
          state_d = S_DISPATCH;
          mode_d  = mode;
          mask_d  = lane_en;
          data_d  = data_in;
          req_d   = lane_en;
        end
      end
      S_DISPATCH: begin
        out_d = out_d | mask_q;
        cnt_d = '0;
        acc_d = '0;
        if ((mask_q == '0) || (mode_q == MODE_NONE)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = (mask_q == '0) ? '0 : data_q;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = acc_q + ack_sum;
        // A join met on the expiry cycle wins over the watchdog.
        if (join_met) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = (mode_q == MODE_ANY) ? any_res : acc_d;
        end else if (expire) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          result_d  = (mode_q == MODE_ANY) ? '0 : acc_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      req_q     <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      req_q     <= req_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign lane_req     = req_q;
  assign lane_data    = data_q;
  assign outstanding  = out_q;
  assign done         = done_q;
  assign result       = result_q;
  assign timeout      = timeout_q;
  assign err_spurious = err_q;

endmodule
